// File: rtl/rffp_dot_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rffp_pkg
// Description : Shared constants and types for the RFFP dot-product
//               accumulator. Holds the default RFFP field widths, the
//               accumulator format, the exponent-bias derivation and the
//               packed operand / accumulator types.
// Revision    : 1.0 - initial release
// ============================================================================
package rffp_pkg;

    localparam int c_rffp_exp_width = 8;
    localparam int c_rffp_man_width = 7;
    localparam int c_acc_width      = 48;
    localparam int c_frac_bits      = 24;
    // Width of the signed alignment shift; far wider than any exponent sum.
    localparam int c_sh_width       = 32;

    // Bias for a symmetric exponent range: 2**(w-1)-1.
    function automatic int exp_bias_of(input int exp_width);
        return (1 << (exp_width - 1)) - 1;
    endfunction

    localparam int c_exp_bias = exp_bias_of(c_rffp_exp_width);

    typedef struct packed {
        logic                        sign;
        logic [c_rffp_exp_width-1:0] exp;
        logic [c_rffp_man_width-1:0] man;
    } rffp_t;

    typedef logic signed [c_acc_width-1:0] acc_t;

endpackage : rffp_pkg
`default_nettype wire

// File: rtl/rffp_dot_acc_prod_align.sv
`default_nettype none
// ============================================================================
// Module      : rffp_prod_align
// Description : Combinational product math for one RFFP operand pair.
//               Path 1 (decode): sign, significand product, alignment shift
//               and zero flag from the raw operands.
//               Path 2 (align): shifts a registered product into the
//               accumulator fixed-point grid, clamps the magnitude to the
//               largest positive accumulator value (pov) and applies sign.
// Ports       : i_a/i_b            raw operands {sign, exp, man}
//               o_s1_*             decoded fields, to be registered by parent
//               i_s2_*             registered decoded fields
//               o_s2_term/o_s2_pov signed aligned term, product-clamp flag
// Revision    : 1.0 - initial release
// ============================================================================
module rffp_prod_align
    import rffp_pkg::*;
#(
    parameter int RFFP_EXP_WIDTH = c_rffp_exp_width,
    parameter int RFFP_MAN_WIDTH = c_rffp_man_width,
    parameter int EXP_BIAS       = c_exp_bias,
    parameter int ACC_WIDTH      = c_acc_width,
    parameter int FRAC_BITS      = c_frac_bits
) (
    input  logic [RFFP_EXP_WIDTH+RFFP_MAN_WIDTH:0] i_a,
    input  logic [RFFP_EXP_WIDTH+RFFP_MAN_WIDTH:0] i_b,
    output logic                                   o_s1_sign,
    output logic [2*RFFP_MAN_WIDTH+1:0]            o_s1_prod,
    output logic signed [c_sh_width-1:0]           o_s1_sh,
    output logic                                   o_s1_zero,
    input  logic                                   i_s2_sign,
    input  logic [2*RFFP_MAN_WIDTH+1:0]            i_s2_prod,
    input  logic signed [c_sh_width-1:0]           i_s2_sh,
    input  logic                                   i_s2_zero,
    output logic signed [ACC_WIDTH-1:0]            o_s2_term,
    output logic                                   o_s2_pov
);

    localparam int c_sig_w  = RFFP_MAN_WIDTH + 1;
    localparam int c_prod_w = 2 * c_sig_w;
    localparam int c_mag_w  = ACC_WIDTH - 1;
    localparam int c_wide_w = c_mag_w + c_prod_w;
    // Folds bias removal, the product's fraction bits and the accumulator
    // fraction bits into one constant offset.
    localparam int c_sh_off = 2 * EXP_BIAS + 2 * RFFP_MAN_WIDTH - FRAC_BITS;

    logic [RFFP_EXP_WIDTH-1:0] w_exp_a;
    logic [RFFP_EXP_WIDTH-1:0] w_exp_b;
    logic [c_sig_w-1:0]        w_sig_a;
    logic [c_sig_w-1:0]        w_sig_b;

    assign w_exp_a   = i_a[RFFP_EXP_WIDTH+RFFP_MAN_WIDTH-1 -: RFFP_EXP_WIDTH];
    assign w_exp_b   = i_b[RFFP_EXP_WIDTH+RFFP_MAN_WIDTH-1 -: RFFP_EXP_WIDTH];
    assign w_sig_a   = {1'b1, i_a[RFFP_MAN_WIDTH-1:0]};
    assign w_sig_b   = {1'b1, i_b[RFFP_MAN_WIDTH-1:0]};

    assign o_s1_sign = i_a[RFFP_EXP_WIDTH+RFFP_MAN_WIDTH] ^ i_b[RFFP_EXP_WIDTH+RFFP_MAN_WIDTH];
    assign o_s1_prod = {{c_sig_w{1'b0}}, w_sig_a} * {{c_sig_w{1'b0}}, w_sig_b};
    assign o_s1_zero = (w_exp_a == '0) || (w_exp_b == '0);
    // Modular 32-bit arithmetic yields the correct signed shift.
    assign o_s1_sh   = c_sh_width'(w_exp_a) + c_sh_width'(w_exp_b) - c_sh_width'(c_sh_off);

    logic [c_wide_w-1:0]         w_wide;
    logic [c_wide_w-1:0]         w_shifted;
    logic signed [c_sh_width-1:0] w_neg_sh;
    logic [c_mag_w-1:0]          w_mag;
    logic signed [ACC_WIDTH-1:0] w_mag_ext;

    always_comb begin
        w_wide    = {{c_mag_w{1'b0}}, i_s2_prod};
        w_neg_sh  = -i_s2_sh;
        w_shifted = '0;
        w_mag     = '0;
        o_s2_pov  = 1'b0;
        if (i_s2_zero || (i_s2_sh <= -c_prod_w)) begin
            w_mag = '0;
        end else if (i_s2_sh < 0) begin
            w_shifted = w_wide >> w_neg_sh;
            w_mag     = w_shifted[c_mag_w-1:0];
        end else if (i_s2_sh >= c_mag_w) begin
            // The product is never zero here, so any shift this large overflows.
            w_mag    = '1;
            o_s2_pov = 1'b1;
        end else begin
            w_shifted = w_wide << i_s2_sh;
            if (|w_shifted[c_wide_w-1:c_mag_w]) begin
                w_mag    = '1;
                o_s2_pov = 1'b1;
            end else begin
                w_mag = w_shifted[c_mag_w-1:0];
            end
        end
        w_mag_ext = {1'b0, w_mag};
        o_s2_term = i_s2_sign ? -w_mag_ext : w_mag_ext;
    end

endmodule : rffp_prod_align
`default_nettype wire

// File: rtl/rffp_dot_acc.sv
`default_nettype none
// ============================================================================
// Module      : rffp_dot_acc
// Description : Streaming RFFP dot-product accumulator. Each accepted pair
//               is multiplied (S1), aligned to a signed fixed-point grid (S2)
//               and accumulated (S3); the vector sum is registered onto a
//               valid/ready output three edges after the last beat.
//               A held output result stalls every stage.
// Config      : RFFP_DOT_ACC_SAT_EN - when defined the accumulator saturates
//               on signed overflow and flags it; otherwise it wraps and
//               out_ovf reports product clamping only.
// Ports       : clk, rst (async, active high)
//               in_a/in_b/in_valid/in_last/in_ready  operand stream
//               out_sum/out_ovf/out_valid/out_ready  result stream
// Revision    : 1.0 - initial release
// ============================================================================
module rffp_dot_acc
    import rffp_pkg::*;
#(
    parameter int RFFP_EXP_WIDTH = c_rffp_exp_width,
    parameter int RFFP_MAN_WIDTH = c_rffp_man_width,
    parameter int EXP_BIAS       = exp_bias_of(RFFP_EXP_WIDTH),
    parameter int ACC_WIDTH      = c_acc_width,
    parameter int FRAC_BITS      = c_frac_bits
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [RFFP_EXP_WIDTH+RFFP_MAN_WIDTH:0] in_a,
    input  logic [RFFP_EXP_WIDTH+RFFP_MAN_WIDTH:0] in_b,
    input  logic                                   in_valid,
    input  logic                                   in_last,
    output logic                                   in_ready,
    output logic signed [ACC_WIDTH-1:0]            out_sum,
    output logic                                   out_ovf,
    output logic                                   out_valid,
    input  logic                                   out_ready
);

    localparam int c_prod_w = 2 * (RFFP_MAN_WIDTH + 1);

    logic                         w_adv;
    logic                         w_in_fire;
    logic                         w_s1_sign;
    logic [c_prod_w-1:0]          w_s1_prod;
    logic signed [c_sh_width-1:0] w_s1_sh;
    logic                         w_s1_zero;
    logic signed [ACC_WIDTH-1:0]  w_s2_term;
    logic                         w_s2_pov;

    logic                         r_s1_valid;
    logic                         r_s1_last;
    logic                         r_s1_sign;
    logic [c_prod_w-1:0]          r_s1_prod;
    logic signed [c_sh_width-1:0] r_s1_sh;
    logic                         r_s1_zero;
    logic                         r_s2_valid;
    logic                         r_s2_last;
    logic signed [ACC_WIDTH-1:0]  r_s2_term;
    logic                         r_s2_pov;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic                         r_ovf_acc;
    logic                         r_first;
    logic                         r_s3_done;

    // Everything freezes only while a result is held unconsumed.
    assign w_adv     = !(out_valid && !out_ready);
    assign in_ready  = w_adv && !rst;
    assign w_in_fire = in_valid && in_ready;

    rffp_prod_align #(
        .RFFP_EXP_WIDTH (RFFP_EXP_WIDTH),
        .RFFP_MAN_WIDTH (RFFP_MAN_WIDTH),
        .EXP_BIAS       (EXP_BIAS),
        .ACC_WIDTH      (ACC_WIDTH),
        .FRAC_BITS      (FRAC_BITS)
    ) u_prod_align (
        .i_a       (in_a),
        .i_b       (in_b),
        .o_s1_sign (w_s1_sign),
        .o_s1_prod (w_s1_prod),
        .o_s1_sh   (w_s1_sh),
        .o_s1_zero (w_s1_zero),
        .i_s2_sign (r_s1_sign),
        .i_s2_prod (r_s1_prod),
        .i_s2_sh   (r_s1_sh),
        .i_s2_zero (r_s1_zero),
        .o_s2_term (w_s2_term),
        .o_s2_pov  (w_s2_pov)
    );

    logic signed [ACC_WIDTH-1:0] w_sum;
    logic signed [ACC_WIDTH-1:0] w_acc_next;
    logic                        w_ovf_next;

`ifdef RFFP_DOT_ACC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] c_acc_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_acc_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    logic w_add_ovf;

    always_comb begin
        w_sum      = r_acc + r_s2_term;
        // Signed overflow: like-signed operands producing an opposite-signed sum.
        w_add_ovf  = !r_first && (r_acc[ACC_WIDTH-1] == r_s2_term[ACC_WIDTH-1]) &&
                     (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
        w_acc_next = r_first   ? r_s2_term :
                     w_add_ovf ? (r_acc[ACC_WIDTH-1] ? c_acc_min : c_acc_max) : w_sum;
        w_ovf_next = (!r_first && r_ovf_acc) || r_s2_pov || w_add_ovf;
    end
`else
    always_comb begin
        w_sum      = r_acc + r_s2_term;
        w_acc_next = r_first ? r_s2_term : w_sum;
        w_ovf_next = (!r_first && r_ovf_acc) || r_s2_pov;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_prod  <= '0;
            r_s1_sh    <= '0;
            r_s1_zero  <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_term  <= '0;
            r_s2_pov   <= 1'b0;
            r_acc      <= '0;
            r_ovf_acc  <= 1'b0;
            r_first    <= 1'b1;
            r_s3_done  <= 1'b0;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_ovf    <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= w_in_fire;
            r_s1_last  <= w_in_fire && in_last;
            r_s1_sign  <= w_s1_sign;
            r_s1_prod  <= w_s1_prod;
            r_s1_sh    <= w_s1_sh;
            r_s1_zero  <= w_s1_zero;
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_term  <= w_s2_term;
            r_s2_pov   <= w_s2_pov;
            if (r_s2_valid) begin
                r_acc     <= w_acc_next;
                r_ovf_acc <= w_ovf_next;
                r_first   <= r_s2_last;
            end
            r_s3_done <= r_s2_valid && r_s2_last;
            // r_acc still holds the finished vector here even if the next
            // vector's first beat overwrites it on this same edge.
            out_valid <= r_s3_done;
            if (r_s3_done) begin
                out_sum <= r_acc;
                out_ovf <= r_ovf_acc;
            end
        end
    end

endmodule : rffp_dot_acc
`default_nettype wire
